// File: rtl/bcd_seq_conv_pkg.sv
// bcd_pkg: shared definitions for the sequential binary-to-BCD converter.
//   state_t    - converter FSM states (IDLE, SHIFT, FINISH)
//   DIGIT_W    - bits per BCD digit
//   cnt_width  - width of a down-counter able to hold the value w
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_seq_conv_if.sv
// bcd_seq_conv_if: start/busy/done handshake and data bus of the converter.
//   start, bin              - request and binary operand (master -> slave)
//   busy, done, bcd, ovf    - status and result (slave -> master)
//   blank                   - leading-zero mask, only when BCD_LZB_EN is defined
// Optional feature macro: BCD_LZB_EN
interface bcd_seq_conv_if #(
  parameter int W      = 10,
  parameter int DIGITS = 4
);
  import bcd_pkg::*;

  logic                       start;
  logic [W-1:0]               bin;
  logic                       busy;
  logic                       done;
  logic [DIGIT_W*DIGITS-1:0]  bcd;
  logic                       ovf;
`ifdef BCD_LZB_EN
  logic [DIGITS-1:0]          blank;

  modport master (output start, bin, input busy, done, bcd, ovf, blank);
  modport slave  (input start, bin, output busy, done, bcd, ovf, blank);
`else
  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
`endif

endinterface

// File: rtl/bcd_seq_conv_add3.sv
// bcd_add3: combinational double-dabble digit corrector.
//   din  - scratch BCD digit before the shift
//   dout - din + 3 when din >= 5, otherwise din unchanged
// Adding 3 before a left shift makes a digit >= 5 carry into the next digit
// exactly as a decimal digit >= 10 would after doubling.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD converter (shift-and-add-3),
// converting one input bit per clock.
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; aborts a running conversion
//   bus  - bcd_seq_conv_if.slave: start/bin in, busy/done/bcd/ovf(/blank) out
// Parameters: W (input width, 4..16), DIGITS (output digits, 1..5).
// Optional feature macro: BCD_LZB_EN adds the registered leading-zero mask.
// A conversion accepted at edge k yields done/bcd/ovf after edge k+W+1;
// start is accepted in IDLE and FINISH, so a held start gives one
// conversion every W+1 clocks.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst,
  bcd_seq_conv_if.slave bus
);

  localparam int CNT_W = cnt_width(W);
  localparam int BCD_W = DIGIT_W * DIGITS;

  state_t             state_reg, state_next;
  logic [W-1:0]       sr_reg, sr_next;
  logic [BCD_W-1:0]   scr_reg, scr_next;
  logic               sticky_reg, sticky_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic               ovf_reg, ovf_next;

  logic [BCD_W-1:0]   scr_corr;
  logic [BCD_W-1:0]   scr_shift;
  logic [W-1:0]       sr_shift;
  logic               shift_out;
  logic               accept;

  // One corrector per scratch digit, applied before every shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (scr_reg [gi*DIGIT_W +: DIGIT_W]),
        .dout (scr_corr[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Whole chain {digits, shift register} moves left by one; the bit that
  // falls off the top digit feeds the sticky overflow flag.
  always_comb begin
    {shift_out, scr_shift, sr_shift} = {scr_corr, sr_reg, 1'b0};
  end

`ifdef BCD_LZB_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  logic [DIGITS-1:0] blank_reg, blank_next, blank_calc;
  logic              upper_zero;

  // blank[i] set when digit i and all digits above it are zero; digit 0
  // is never blanked so a zero result still shows one "0".
  always_comb begin
    blank_calc = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (scr_reg[i*DIGIT_W +: DIGIT_W] == '0);
      blank_calc[i] = upper_zero;
    end
  end
`endif

  // FINISH behaves like IDLE for accepting a new request.
  always_comb begin
    accept = bus.start && ((state_reg == IDLE) || (state_reg == FINISH));
  end

  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    scr_next    = scr_reg;
    sticky_next = sticky_reg;
    cnt_next    = cnt_reg;
    done_next   = 1'b0;
    bcd_next    = bcd_reg;
    ovf_next    = ovf_reg;
`ifdef BCD_LZB_EN
    blank_next  = blank_reg;
`endif

    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end
      SHIFT: begin
        sr_next     = sr_shift;
        scr_next    = scr_shift;
        sticky_next = sticky_reg | shift_out;
        cnt_next    = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        bcd_next   = scr_reg;
        ovf_next   = sticky_reg;
        done_next  = 1'b1;
`ifdef BCD_LZB_EN
        blank_next = blank_calc;
`endif
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      sr_next     = bus.bin;
      scr_next    = '0;
      sticky_next = 1'b0;
      cnt_next    = CNT_W'(W);
      state_next  = SHIFT;
    end

    busy_next = (state_next == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sr_reg     <= '0;
      scr_reg    <= '0;
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      bcd_reg    <= '0;
      ovf_reg    <= 1'b0;
`ifdef BCD_LZB_EN
      blank_reg  <= BLANK_RST;
`endif
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      scr_reg    <= scr_next;
      sticky_reg <= sticky_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      bcd_reg    <= bcd_next;
      ovf_reg    <= ovf_next;
`ifdef BCD_LZB_EN
      blank_reg  <= blank_next;
`endif
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.bcd   = bcd_reg;
  assign bus.ovf   = ovf_reg;
`ifdef BCD_LZB_EN
  assign bus.blank = blank_reg;
`endif

endmodule
